// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL supervisor control/status bundle
//
// Groups the PLL-facing and status signals of pll_lock_supervisor.
//   pll_locked      raw PLL lock (asynchronous to refclk)
//   force_relock    single-cycle request to restart the PLL
//   clear_fault     single-cycle request to leave FAULT
//   pll_rst         active-high reset to the PLL
//   ready           PLL locked and qualified
//   fault           retry budget exhausted (sticky)
//   lock_lost       one-cycle pulse on lock loss in RUN
//   retry_count     consecutive failed attempts, saturating
//   lock_loss_count total RUN lock losses, saturating
//   state           encoded supervisor state
// master: the side issuing requests and observing status.
// slave:  the supervisor itself.

interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       force_relock;
    logic       clear_fault;
    logic       pll_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    modport master (
        output pll_locked,
        output force_relock,
        output clear_fault,
        input  pll_rst,
        input  ready,
        input  fault,
        input  lock_lost,
        input  retry_count,
        input  lock_loss_count,
        input  state
    );

    modport slave (
        input  pll_locked,
        input  force_relock,
        input  clear_fault,
        output pll_rst,
        output ready,
        output fault,
        output lock_lost,
        output retry_count,
        output lock_loss_count,
        output state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and retry policy
//
// Ports:
//   refclk  reference clock, the only clock
//   rst_n   asynchronous active-low reset
//   bus     pll_lock_supervisor_if.slave (PLL lock in, requests in,
//           pll_rst/ready/fault/lock_lost/counters/state out)
//
// States: RESET_PLL=0, WAIT_LOCK=1, STABILISE=2, RUN=3, FAULT=4.
// One shared cycle counter times the reset hold, the lock timeout and the
// stability window, since only one of them is active at a time.

module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int STABLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2,
    parameter int CNT_W               = 16
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILISE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);
    localparam bit               RETRY_BOUNDED = (MAX_RETRIES != 0);

    // ------------------------------------------------------------------
    // Lock synchroniser; nothing downstream looks at the raw pll_locked.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             lost_d;
    logic             retry_req;

    logic             pll_rst_q;
    logic             ready_q;
    logic             fault_q;
    logic             lock_lost_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state register instead of one cycle later.
            pll_rst_q   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
            ready_q     <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
            lock_lost_q <= lost_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        lost_d    = 1'b0;
        retry_req = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABILISE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STABILISE: begin
                // A dropout sends us back to waiting with a fresh timeout
                // rather than counting as a failed attempt.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (!lock_s) begin
                    lost_d    = 1'b1;
                    loss_d    = sat_inc(loss_q);
                    retry_req = 1'b1;
                end
            end

            ST_FAULT: begin
                if (bus.clear_fault) begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Retry decision resolves in the same cycle as the failure. The
        // check happens before the increment, so FAULT follows the
        // (MAX_RETRIES+1)th consecutive failure.
        if (retry_req) begin
            cnt_d = '0;
            if (RETRY_BOUNDED && (retry_q == RETRY_LIMIT)) begin
                state_d = ST_FAULT;
            end else begin
                retry_d = sat_inc(retry_q);
                state_d = ST_RESET_PLL;
            end
        end

        // A relock request overrides any same-cycle loss or timeout and
        // leaves the failure bookkeeping untouched. FAULT only exits via
        // clear_fault.
        if (bus.force_relock && (state_q != ST_FAULT)) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = retry_q;
            loss_d  = loss_q;
            lost_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pll_rst         = pll_rst_q;
    assign bus.ready           = ready_q;
    assign bus.fault           = fault_q;
    assign bus.lock_lost       = lock_lost_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.state           = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed table-driven bench for pll_lock_supervisor

module tb_pll_lock_supervisor;

    logic refclk;
    logic rst_n;

    pll_lock_supervisor_if bus_if ();

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES(50),
        .STABLE_CYCLES      (8),
        .MAX_RETRIES        (2),
        .SYNC_STAGES        (2),
        .CNT_W              (16)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic       lk;
        logic       fr;
        logic       cf;
        int         n;
        logic [2:0] st;
        logic       prst;
        logic       rdy;
        logic       flt;
        logic       ll;
        logic [7:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic lk, input logic fr, input logic cf, input int n,
                       input logic [2:0] st, input logic prst, input logic rdy,
                       input logic flt, input logic ll, input logic [7:0] rc,
                       input logic [7:0] lc);
        vec_t v;
        v.lk = lk; v.fr = fr; v.cf = cf; v.n = n;
        v.st = st; v.prst = prst; v.rdy = rdy; v.flt = flt; v.ll = ll;
        v.rc = rc; v.lc = lc;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s rec=%0d got=%0d want=%0d", name, idx, got, want);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] st, input logic prst,
                             input logic rdy, input logic flt, input logic ll,
                             input logic [7:0] rc, input logic [7:0] lc);
        check("state",           idx, 8'(bus_if.state),     8'(st));
        check("pll_rst",         idx, 8'(bus_if.pll_rst),   8'(prst));
        check("ready",           idx, 8'(bus_if.ready),     8'(rdy));
        check("fault",           idx, 8'(bus_if.fault),     8'(flt));
        check("lock_lost",       idx, 8'(bus_if.lock_lost), 8'(ll));
        check("retry_count",     idx, bus_if.retry_count,     rc);
        check("lock_loss_count", idx, bus_if.lock_loss_count, lc);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus_if.pll_locked   = tbl[i].lk;
            bus_if.force_relock = tbl[i].fr;
            bus_if.clear_fault  = tbl[i].cf;
            repeat (tbl[i].n) @(posedge refclk);
            #1;
            check_all(i, tbl[i].st, tbl[i].prst, tbl[i].rdy, tbl[i].flt,
                      tbl[i].ll, tbl[i].rc, tbl[i].lc);
        end
        bus_if.force_relock = 1'b0;
        bus_if.clear_fault  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int split;
        bit seen;

        // lk fr cf  n   st prst rdy flt ll rc lc
        // Clean start: pll_rst 4 cycles, lock raised 10 cycles into WAIT_LOCK.
        add(0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 9,  1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 2,  1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 7,  2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1,  3, 0, 1, 0, 0, 0, 0);
        // force_relock on the very edge synchronised lock drops in RUN.
        add(0, 0, 0, 2,  3, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
        // Glitchy lock: high 5, low 1, then high.
        add(1, 0, 0, 5,  2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 2,  1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1,  2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 7,  2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1,  3, 0, 1, 0, 0, 0, 0);
        // Lock loss in RUN, then relock.
        add(0, 0, 0, 2,  3, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1,  0, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1,  0, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 2,  0, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1,  1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1,  2, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 7,  2, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1,  3, 0, 1, 0, 0, 0, 1);
        split = tbl.size();
        // Timeouts to fault after an asynchronous reset.
        add(0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 49, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 3,  0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 49, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1,  0, 1, 0, 0, 0, 2, 0);
        add(0, 0, 0, 3,  0, 1, 0, 0, 0, 2, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 49, 1, 0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 1,  4, 1, 0, 1, 0, 2, 0);
        add(0, 0, 0, 20, 4, 1, 0, 1, 0, 2, 0);
        add(0, 1, 0, 1,  4, 1, 0, 1, 0, 2, 0);
        add(0, 1, 1, 1,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);

        rst_n               = 1'b0;
        bus_if.pll_locked   = 1'b0;
        bus_if.force_relock = 1'b0;
        bus_if.clear_fault  = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        check_all(-1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        @(negedge refclk);
        rst_n = 1'b1;
        run_range(0, split);

        // Asynchronous reset while in STABILISE.
        bus_if.pll_locked   = 1'b1;
        bus_if.force_relock = 1'b1;
        @(posedge refclk);
        #1;
        bus_if.force_relock = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge refclk);
            #1;
            if (bus_if.state == 3'd2) seen = 1'b1;
        end
        check("reach_stabilise", -2, 8'(seen), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(-3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge refclk);
        bus_if.pll_locked = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;
        run_range(split, tbl.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
